// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: gain, binary-angle constants, FSM encoding and the
// arctangent table used by both the rotation and vectoring CORDIC blocks.
package cordic_pkg;

  localparam real CORDIC_K = 1.6467602581;

  localparam logic [31:0] ANGLE_PI   = 32'h8000_0000;
  localparam logic [31:0] ANGLE_PI_2 = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // round(atan(2^-i) / (2*pi) * 2^32)
  localparam logic [31:0] ATAN32 [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  function automatic logic [63:0] angle_pi(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // ATAN[i] rescaled from the 32-bit reference table to a width-bit angle.
  function automatic logic [63:0] atan_entry(input int idx, input int width);
    logic [63:0] wide;
    if (idx < 32 && idx >= 0) begin
      wide = {32'd0, ATAN32[idx[4:0]]};
    end else begin
      wide = 64'd0;
    end
    if (width == 32) begin
      atan_entry = wide;
    end else if (width < 32) begin
      atan_entry = (wide + (64'd1 << (31 - width))) >> (32 - width);
    end else begin
      atan_entry = wide << (width - 32);
    end
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: micro-rotation index in, binary angle out.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] angle_step
);

  // Table lookup scaled to the angle width
  always_comb begin
    angle_step = WIDTH'(atan_entry(int'(index), WIDTH));
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> gain-scaled magnitude and atan2
// angle, one micro-rotation per clock, valid/ready on both sides.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] mag,
  output logic signed [WIDTH-1:0] angle
);

  localparam int DW    = WIDTH + 2;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_ITER = IDX_W'(ITERATIONS - 1);

  state_t                  state_r, state_s;
  logic signed [DW-1:0]    x_r, y_r, x_nx_s, y_nx_s, x_sh_s, y_sh_s;
  logic signed [DW-1:0]    x_ext_s, y_ext_s;
  logic [WIDTH-1:0]        z_r, z_nx_s, atan_s, mag_sat_s;
  logic [IDX_W-1:0]        iter_r;
  logic                    zero_r;

  cordic_atan_rom #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_atan_rom (
    .index      (iter_r),
    .angle_step (atan_s)
  );

  assign x_ext_s = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext_s = {{2{y_in[WIDTH-1]}}, y_in};

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_s = ROTATE; else state_s = IDLE;
      ROTATE:  if (iter_r == LAST_ITER) state_s = DONE; else state_s = ROTATE;
      DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // One micro-rotation; all updates use the pre-update x/y
  always_comb begin
    x_sh_s = x_r >>> iter_r;
    y_sh_s = y_r >>> iter_r;
    if (!y_r[DW-1]) begin
      x_nx_s = x_r + y_sh_s;
      y_nx_s = y_r - x_sh_s;
      z_nx_s = z_r + atan_s;
    end else begin
      x_nx_s = x_r - y_sh_s;
      y_nx_s = y_r + x_sh_s;
      z_nx_s = z_r - atan_s;
    end
  end

  // Final x clamped into the non-negative signed output range
  always_comb begin
    if (x_nx_s[DW-1]) begin
      mag_sat_s = '0;
    end else if (|x_nx_s[DW-2:WIDTH-1]) begin
      mag_sat_s = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      mag_sat_s = x_nx_s[WIDTH-1:0];
    end
  end

  // State, datapath and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag       <= '0;
      angle     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      iter_r    <= '0;
      zero_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            iter_r <= '0;
            zero_r <= (x_in == '0) && (y_in == '0);
            // Left half-plane: rotate by pi so the iterations converge
            if (x_in[WIDTH-1]) begin
              x_r <= -x_ext_s;
              y_r <= -y_ext_s;
              z_r <= WIDTH'(angle_pi(WIDTH));
            end else begin
              x_r <= x_ext_s;
              y_r <= y_ext_s;
              z_r <= '0;
            end
          end
        end
        ROTATE: begin
          x_r    <= x_nx_s;
          y_r    <= y_nx_s;
          z_r    <= z_nx_s;
          iter_r <= iter_r + 1'b1;
          if (iter_r == LAST_ITER) begin
            mag   <= zero_r ? '0 : mag_sat_s;
            angle <= zero_r ? '0 : z_nx_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Table-driven bench for cordic_vectoring (WIDTH=32, ITERATIONS=31) plus
// backpressure and mid-computation reset sequences.
module tb_cordic_vectoring;

  localparam int W = 32;
  localparam int N = 31;

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] mag;
    logic signed [31:0] angle;
    int                 tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic signed [W-1:0] mag, angle;

  int checks = 0;
  int errors = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  cordic_vectoring #(.WIDTH(W), .ITERATIONS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mag       (mag),
    .angle     (angle)
  );

  // Modular difference, so angles near +/-pi compare across the wrap.
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp, input int tol);
    logic signed [31:0] d;
    d = got - exp;
    checks++;
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (tol %0d)", name, $signed(got), $signed(exp), tol);
    end
  endtask

  task automatic start_vec(input logic signed [31:0] x, input logic signed [31:0] y);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", {31'd0, in_ready}, 32'd1, 0);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("ready_after_release", {31'd0, in_ready}, 32'd1, 0);
    check("valid_after_release", {31'd0, out_valid}, 32'd0, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] m0, a0;
    logic stable;
    logic quiet;

    vecs[0] = '{ 32'sd268435456,  32'sd0,          32'sd442048831,  32'sd0,           64};
    vecs[1] = '{ 32'sd0,          32'sd268435456,  32'sd442048831,  32'sd1073741824,  64};
    vecs[2] = '{-32'sd268435456,  32'sd0,          32'sd442048831,  32'sh8000_0000,   64};
    vecs[3] = '{ 32'sd268435456,  32'sd268435456,  32'sd625151449,  32'sd536870912,   64};
    vecs[4] = '{ 32'sd0,          32'sd0,          32'sd0,          32'sd0,           0};
    vecs[5] = '{-32'sd268435456,  32'sd268435456,  32'sd625151449,  32'sd1610612736,  64};
    vecs[6] = '{-32'sd268435456, -32'sd268435456,  32'sd625151449, -32'sd1610612736,  64};
    vecs[7] = '{ 32'sd536870912, -32'sd536870912,  32'sd1250302932, -32'sd536870912,  64};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1, 0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
    check("rst_mag", mag, 32'd0, 0);
    check("rst_angle", angle, 32'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_vec(vecs[i].x, vecs[i].y);
      check("busy_after_accept", {31'd0, in_ready}, 32'd0, 0);
      wait_out(lat);
      check("latency", lat, N, 0);
      check("mag", mag, vecs[i].mag, vecs[i].tol);
      check("angle", angle, vecs[i].angle, vecs[i].tol);
      release_out();
    end

    // Backpressure: result held, second vector ignored until released
    start_vec(32'sd268435456, 32'sd0);
    wait_out(lat);
    check("bp_latency", lat, N, 0);
    m0 = mag;
    a0 = angle;
    @(negedge clk);
    x_in = 32'sd0;
    y_in = 32'sd268435456;
    in_valid = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (mag != m0 || angle != a0 || !out_valid || in_ready) stable = 1'b0;
    end
    check("bp_stable", {31'd0, stable}, 32'd1, 0);
    check("bp_mag", m0, 32'sd442048831, 64);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_ready_rise", {31'd0, in_ready}, 32'd1, 0);
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_second_accepted", {31'd0, in_ready}, 32'd0, 0);
    wait_out(lat);
    check("bp2_latency", lat, N, 0);
    check("bp2_mag", mag, 32'sd442048831, 64);
    check("bp2_angle", angle, 32'sd1073741824, 64);
    release_out();

    // Reset at iteration 10 aborts the computation
    start_vec(32'sd268435456, 32'sd268435456);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
    check("mid_rst_mag", mag, 32'd0, 0);
    check("mid_rst_angle", angle, 32'd0, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1, 0);
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) quiet = 1'b0;
    end
    check("no_stale_result", {31'd0, quiet}, 32'd1, 0);
    start_vec(32'sd0, -32'sd268435456);
    wait_out(lat);
    check("post_rst_latency", lat, N, 0);
    check("post_rst_mag", mag, 32'sd442048831, 64);
    check("post_rst_angle", angle, -32'sd1073741824, 64);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
